// File: rtl/jr_target_resolver.sv
// ID-stage JR/JALR target resolver: forwards rs from MEM/WB, stalls on EX or load producers,
// then issues a one-cycle PC redirect with IF flush. Define JR_ALIGN_CHECK_EN to add addr_exc.
module jr_target_resolver #(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] rf_rs_data,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_reg,
  input  logic        mem_wr_en,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_wr_reg,
  input  logic [31:0] mem_wr_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_reg,
  input  logic [31:0] wb_wr_data,
  output logic        stall_id,
  output logic        pc_redirect,
  output logic        flush_if,
  output logic [31:0] pc_target,
`ifdef JR_ALIGN_CHECK_EN
  output logic        addr_exc,
`endif
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       rs;
  logic             is_jr, rs_nz, hazard, resolve, stall_raw;
  logic [31:0]      operand;
  logic             unused_inst;

  assign rs          = id_inst[25:21];
  assign rs_nz       = (rs != 5'd0);
  assign is_jr       = id_valid & (id_inst[31:26] == 6'd0) & (id_inst[5:1] == 5'b00100);
  assign unused_inst = ^id_inst[20:6];

  // r0 never hazards and never forwards: it reads as zero regardless of pipeline writes
  assign hazard = rs_nz & ((ex_wr_en & (ex_wr_reg == rs)) |
                           (mem_wr_en & mem_is_load & (mem_wr_reg == rs)));

  always_comb begin
    operand = rf_rs_data;
    if (!rs_nz)                              operand = 32'h0;
    else if (mem_wr_en && mem_wr_reg == rs)  operand = mem_wr_data;
    else if (wb_wr_en && wb_wr_reg == rs)    operand = wb_wr_data;
  end

`ifdef JR_ALIGN_CHECK_EN
  logic mis_q;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    resolve     = 1'b0;
    stall_raw   = 1'b0;
    pc_redirect = 1'b0;
    flush_if    = 1'b0;
`ifdef JR_ALIGN_CHECK_EN
    addr_exc    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (is_jr) begin
          if (hazard) begin
            stall_raw = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = S_WAIT;
          end else begin
            resolve   = 1'b1;
            state_nxt = S_REDIR;
          end
        end
      end
      S_WAIT: begin
        // the jump is held in ID by our own stall, so the slot is re-evaluated each cycle
        if (hazard) begin
          stall_raw = 1'b1;
          cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else begin
          resolve   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_REDIR;
        end
      end
      S_REDIR: begin
        flush_if  = 1'b1;
`ifdef JR_ALIGN_CHECK_EN
        pc_redirect = ~mis_q;
        addr_exc    = mis_q;
`else
        pc_redirect = 1'b1;
`endif
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall_id = stall_raw & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc_target   <= 32'h0;
      timeout_err <= 1'b0;
`ifdef JR_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (resolve) begin
        pc_target <= operand;
`ifdef JR_ALIGN_CHECK_EN
        mis_q     <= |operand[1:0];
`endif
      end
      if (stall_raw && cnt_nxt >= STALL_LIM) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jr_target_resolver.sv
// Bench for jr_target_resolver: table of single-cycle jump/non-jump vectors plus stall,
// timeout and reset sequences; expected targets go through a scoreboard queue.
module tb_jr_target_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_inst, rf_rs_data, mem_wr_data, wb_wr_data;
  logic        ex_wr_en, mem_wr_en, mem_is_load, wb_wr_en;
  logic [4:0]  ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic        stall_id, pc_redirect, flush_if, timeout_err;
  logic [31:0] pc_target;
`ifdef JR_ALIGN_CHECK_EN
  logic        addr_exc;
`endif

  jr_target_resolver #(.MAX_STALL(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
    .rf_rs_data(rf_rs_data), .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_reg(mem_wr_reg),
    .mem_wr_data(mem_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .wb_wr_data(wb_wr_data), .stall_id(stall_id), .pc_redirect(pc_redirect),
    .flush_if(flush_if), .pc_target(pc_target),
`ifdef JR_ALIGN_CHECK_EN
    .addr_exc(addr_exc),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] rf;
    logic        ex_en;
    logic [4:0]  ex_reg;
    logic        mem_en;
    logic        mem_ld;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        exp_jump;
    logic [31:0] exp_tgt;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] last_tgt = 32'h0;
  vec_t        vt[11];

  function automatic logic [31:0] mk_inst(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [5:0] fn);
    return {op, rs, 5'd0, 5'd0, 5'd0, fn};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] in, input logic [31:0] rf,
                              input logic ee, input logic [4:0] er,
                              input logic me, input logic ml, input logic [4:0] mr,
                              input logic [31:0] md, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic ej, input logic [31:0] et);
    vec_t r;
    r.valid = v; r.inst = in; r.rf = rf; r.ex_en = ee; r.ex_reg = er;
    r.mem_en = me; r.mem_ld = ml; r.mem_reg = mr; r.mem_data = md;
    r.wb_en = we; r.wb_reg = wr; r.wb_data = wd; r.exp_jump = ej; r.exp_tgt = et;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_inst = 32'h0; rf_rs_data = 32'h0;
    ex_wr_en = 1'b0; ex_wr_reg = 5'd0;
    mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_reg = 5'd0; mem_wr_data = 32'h0;
    wb_wr_en = 1'b0; wb_wr_reg = 5'd0; wb_wr_data = 32'h0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = v.valid; id_inst = v.inst; rf_rs_data = v.rf;
    ex_wr_en = v.ex_en; ex_wr_reg = v.ex_reg;
    mem_wr_en = v.mem_en; mem_is_load = v.mem_ld; mem_wr_reg = v.mem_reg;
    mem_wr_data = v.mem_data;
    wb_wr_en = v.wb_en; wb_wr_reg = v.wb_reg; wb_wr_data = v.wb_data;
  endtask

  // called at the negedge of the cycle that must carry the redirect
  task automatic expect_redirect(input string name);
    logic [31:0] e;
    check({name, ".pc_redirect"}, {31'd0, pc_redirect}, 32'd1);
    check({name, ".flush_if"}, {31'd0, flush_if}, 32'd1);
    check({name, ".stall_id"}, {31'd0, stall_id}, 32'd0);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s.scoreboard: got empty queue, expected one pending target", name);
    end else begin
      e = sb.pop_front();
      check({name, ".pc_target"}, pc_target, e);
      last_tgt = e;
    end
  endtask

  task automatic expect_quiet(input string name);
    check({name, ".pc_redirect"}, {31'd0, pc_redirect}, 32'd0);
    check({name, ".flush_if"}, {31'd0, flush_if}, 32'd0);
    check({name, ".pc_target_hold"}, pc_target, last_tgt);
  endtask

  localparam logic [5:0] F_JR = 6'b001000, F_JALR = 6'b001001;

  initial begin
    vt[0]  = mk(1, mk_inst(0, 5'd5, F_JR),   32'h40,   0, 0,  0, 0, 0,  0,        0, 0,  0,        1, 32'h40);
    vt[1]  = mk(1, mk_inst(0, 5'd3, F_JALR), 32'hdead, 0, 0,  1, 0, 3,  32'h100,  0, 0,  0,        1, 32'h100);
    vt[2]  = mk(1, mk_inst(0, 5'd7, F_JR),   32'h4,    0, 0,  0, 0, 0,  0,        1, 7,  32'h2000, 1, 32'h2000);
    vt[3]  = mk(1, mk_inst(0, 5'd0, F_JR),   32'h77,   1, 0,  0, 0, 0,  0,        0, 0,  0,        1, 32'h0);
    vt[4]  = mk(1, mk_inst(0, 5'd9, F_JR),   32'h8,    0, 0,  1, 0, 9,  32'h300,  1, 9,  32'h400,  1, 32'h300);
    vt[5]  = mk(1, mk_inst(0, 5'd5, 6'b001010), 32'h500, 0, 0, 0, 0, 0, 0,        0, 0,  0,        0, 32'h0);
    vt[6]  = mk(1, mk_inst(6'd2, 5'd5, F_JR), 32'h600, 0, 0,  0, 0, 0,  0,        0, 0,  0,        0, 32'h0);
    vt[7]  = mk(0, mk_inst(0, 5'd5, F_JR),   32'h700,  0, 0,  0, 0, 0,  0,        0, 0,  0,        0, 32'h0);
    vt[8]  = mk(1, mk_inst(0, 5'd0, F_JALR), 32'h9,    1, 0,  1, 1, 0,  32'h55,   1, 0,  32'h66,   1, 32'h0);
    vt[9]  = mk(1, mk_inst(0, 5'd4, F_JR),   32'h1234, 1, 5,  1, 1, 6,  32'h99,   0, 0,  0,        1, 32'h1234);
    vt[10] = mk(1, mk_inst(0, 5'd2, F_JR),   32'h88,   0, 0,  0, 1, 2,  32'hbad,  1, 3,  32'hbee,  1, 32'h88);

    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.stall_id", {31'd0, stall_id}, 32'd0);
    check("reset.timeout_err", {31'd0, timeout_err}, 32'd0);
    expect_quiet("reset");
    reset = 1'b1;

    // each vector is decoded from IDLE; the following cycle is REDIRECT or quiet
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive_vec(vt[i]);
      @(negedge clk);
      check($sformatf("vec%0d.stall_id", i), {31'd0, stall_id}, 32'd0);
      check($sformatf("vec%0d.no_early_redirect", i), {31'd0, pc_redirect}, 32'd0);
      if (vt[i].exp_jump) sb.push_back(vt[i].exp_tgt);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      if (vt[i].exp_jump) expect_redirect($sformatf("vec%0d", i));
      else                expect_quiet($sformatf("vec%0d", i));
    end

    // JALR r3: EX producer stalls one cycle, then MEM forwards 0x100
    @(posedge clk); #1;
    drive_idle();
    id_valid = 1; id_inst = mk_inst(0, 5'd3, F_JALR); rf_rs_data = 32'hdead;
    ex_wr_en = 1; ex_wr_reg = 5'd3;
    @(negedge clk);
    check("exhaz.stall_id", {31'd0, stall_id}, 32'd1);
    check("exhaz.flush_if", {31'd0, flush_if}, 32'd0);
    @(posedge clk); #1;
    ex_wr_en = 0; mem_wr_en = 1; mem_wr_reg = 5'd3; mem_wr_data = 32'h100;
    @(negedge clk);
    check("exhaz.resolve_stall", {31'd0, stall_id}, 32'd0);
    check("exhaz.no_redirect_yet", {31'd0, pc_redirect}, 32'd0);
    sb.push_back(32'h100);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    expect_redirect("exhaz");

    // JR r7: load in MEM stalls, then WB supplies 0x2000
    @(posedge clk); #1;
    id_valid = 1; id_inst = mk_inst(0, 5'd7, F_JR); rf_rs_data = 32'h1;
    mem_wr_en = 1; mem_is_load = 1; mem_wr_reg = 5'd7; mem_wr_data = 32'hbad0;
    @(negedge clk);
    check("ldhaz.stall_id", {31'd0, stall_id}, 32'd1);
    @(posedge clk); #1;
    mem_wr_en = 0; mem_is_load = 0; wb_wr_en = 1; wb_wr_reg = 5'd7; wb_wr_data = 32'h2000;
    @(negedge clk);
    check("ldhaz.resolve_stall", {31'd0, stall_id}, 32'd0);
    sb.push_back(32'h2000);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    expect_redirect("ldhaz");

    // persistent hazard: timeout_err rises after the 8th stall cycle and holds
    @(posedge clk); #1;
    id_valid = 1; id_inst = mk_inst(0, 5'd6, F_JR); rf_rs_data = 32'h3000;
    ex_wr_en = 1; ex_wr_reg = 5'd6;
    @(negedge clk);
    check("tmo.c1.stall_id", {31'd0, stall_id}, 32'd1);
    check("tmo.c1.timeout_err", {31'd0, timeout_err}, 32'd0);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("tmo.c%0d.stall_id", k), {31'd0, stall_id}, 32'd1);
      check($sformatf("tmo.c%0d.timeout_err", k), {31'd0, timeout_err}, (k >= 9) ? 32'd1 : 32'd0);
      check($sformatf("tmo.c%0d.pc_redirect", k), {31'd0, pc_redirect}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    last_tgt = 32'h0;
    @(negedge clk);
    check("tmo_rst.stall_id", {31'd0, stall_id}, 32'd0);
    check("tmo_rst.timeout_err", {31'd0, timeout_err}, 32'd0);
    expect_quiet("tmo_rst");
    @(negedge clk);
    expect_quiet("tmo_rst_next");

`ifdef JR_ALIGN_CHECK_EN
    @(posedge clk); #1;
    id_valid = 1; id_inst = mk_inst(0, 5'd5, F_JR); rf_rs_data = 32'h42;
    @(negedge clk);
    check("align.stall_id", {31'd0, stall_id}, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("align.addr_exc", {31'd0, addr_exc}, 32'd1);
    check("align.pc_redirect", {31'd0, pc_redirect}, 32'd0);
    check("align.flush_if", {31'd0, flush_if}, 32'd1);
    check("align.pc_target", pc_target, 32'h42);
    @(negedge clk);
    check("align.addr_exc_pulse", {31'd0, addr_exc}, 32'd0);
`endif

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard.drain: got %0d pending targets, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
